// File: rtl/bist_resp_analyzer.sv
// Memory BIST response analyzer: compares read data against expected data,
// counts reads and mismatches, captures the first failure, and reports pass/fail.
module bist_resp_analyzer #(
    parameter int unsigned DTA_SIZE  = 8,
    parameter int unsigned ADR_SIZE  = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rd_valid,
    input  logic                 rd_up,
    input  logic [ADR_SIZE-1:0]  rd_addr,
    input  logic [DTA_SIZE-1:0]  rd_data,
    input  logic [DTA_SIZE-1:0]  exp_data,
    input  logic                 test_end,
    output logic                 busy,
    output logic                 done,
    output logic                 status,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 count_err,
    output logic                 fail_valid,
    output logic [ADR_SIZE-1:0]  fail_addr,
    output logic [DTA_SIZE-1:0]  fail_syn,
    output logic                 fail_up
);
    localparam int unsigned CNT_W = ADR_SIZE + 2;
    // Full March run reads every word twice: 2**(ADR_SIZE+1)
    localparam logic [CNT_W-1:0] RD_TARGET = {2'b01, {ADR_SIZE{1'b0}}} << 1;

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN, RESULT} state_t;

    state_t                state, state_nxt;
    logic                  s1_valid, s1_valid_nxt, s1_load_c;
    logic [ADR_SIZE-1:0]   s1_addr;
    logic                  s1_up;
    logic [DTA_SIZE-1:0]   s1_syn;
    logic [CNT_W-1:0]      rd_cnt, rd_cnt_nxt;
    logic [ERR_CNT_W-1:0]  err_cnt_nxt;
    logic                  fail_valid_nxt, fail_up_nxt;
    logic [ADR_SIZE-1:0]   fail_addr_nxt;
    logic [DTA_SIZE-1:0]   fail_syn_nxt;
    logic                  busy_nxt, done_nxt, status_nxt, count_err_nxt;
    logic                  s2_miss_c;

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            s1_up      <= 1'b0;
            s1_syn     <= '0;
            rd_cnt     <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_addr  <= '0;
            fail_syn   <= '0;
            fail_up    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            status     <= 1'b0;
            count_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            s1_valid   <= s1_valid_nxt;
            if (s1_load_c) begin
                s1_addr <= rd_addr;
                s1_up   <= rd_up;
                s1_syn  <= rd_data ^ exp_data;
            end
            rd_cnt     <= rd_cnt_nxt;
            err_cnt    <= err_cnt_nxt;
            fail_valid <= fail_valid_nxt;
            fail_addr  <= fail_addr_nxt;
            fail_syn   <= fail_syn_nxt;
            fail_up    <= fail_up_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            status     <= status_nxt;
            count_err  <= count_err_nxt;
        end
    end

    // Next-state, S1 capture, S2 counting and result evaluation
    always_comb begin
        state_nxt      = state;
        s1_load_c      = 1'b0;
        s1_valid_nxt   = 1'b0;
        s2_miss_c      = s1_valid && (s1_syn != '0);
        rd_cnt_nxt     = rd_cnt;
        err_cnt_nxt    = err_cnt;
        fail_valid_nxt = fail_valid;
        fail_addr_nxt  = fail_addr;
        fail_syn_nxt   = fail_syn;
        fail_up_nxt    = fail_up;
        status_nxt     = status;
        count_err_nxt  = count_err;

        case (state)
            IDLE:    if (start) state_nxt = ARMED;
            ARMED:   if (test_end) state_nxt = DRAIN;
            DRAIN:   state_nxt = RESULT;
            RESULT:  state_nxt = RESULT;
            default: state_nxt = IDLE;
        endcase

        s1_load_c    = (state == ARMED) && rd_valid && !start;
        s1_valid_nxt = s1_load_c;

        if (s1_valid && (rd_cnt != '1))
            rd_cnt_nxt = rd_cnt + CNT_W'(1);
        if (s2_miss_c && (err_cnt != '1))
            err_cnt_nxt = err_cnt + ERR_CNT_W'(1);
        if (s2_miss_c && !fail_valid) begin
            fail_valid_nxt = 1'b1;
            fail_addr_nxt  = s1_addr;
            fail_syn_nxt   = s1_syn;
            fail_up_nxt    = s1_up;
        end

        // Results freeze on the edge the last S1 entry retires
        if (state == DRAIN) begin
            count_err_nxt = (rd_cnt_nxt != RD_TARGET);
            status_nxt    = (err_cnt_nxt == '0) && (rd_cnt_nxt == RD_TARGET);
        end

        if (start) begin
            state_nxt      = ARMED;
            rd_cnt_nxt     = '0;
            err_cnt_nxt    = '0;
            fail_valid_nxt = 1'b0;
            fail_addr_nxt  = '0;
            fail_syn_nxt   = '0;
            fail_up_nxt    = 1'b0;
            status_nxt     = 1'b0;
            count_err_nxt  = 1'b0;
        end

        busy_nxt = (state_nxt == ARMED) || (state_nxt == DRAIN);
        done_nxt = (state_nxt == RESULT);
    end
endmodule

// File: tb/tb_bist_resp_analyzer.sv
// Scoreboarded random/directed bench for bist_resp_analyzer; a second instance
// with a 2-bit error counter exercises saturation on the same stimulus.
module tb_bist_resp_analyzer;
    localparam int unsigned DW = 8, AW = 4, EW = 8, EW2 = 2;

    logic clk = 1'b0;
    logic rst, start, rd_valid, rd_up, test_end;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, exp_data;

    logic busy, done, status, count_err, fail_valid, fail_up;
    logic [EW-1:0] err_cnt;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_syn;

    logic busy_b, done_b, status_b, count_err_b, fail_valid_b, fail_up_b;
    logic [EW2-1:0] err_cnt_b;
    logic [AW-1:0]  fail_addr_b;
    logic [DW-1:0]  fail_syn_b;

    bist_resp_analyzer #(.DTA_SIZE(DW), .ADR_SIZE(AW), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_valid(rd_valid), .rd_up(rd_up),
        .rd_addr(rd_addr), .rd_data(rd_data), .exp_data(exp_data), .test_end(test_end),
        .busy(busy), .done(done), .status(status), .err_cnt(err_cnt),
        .count_err(count_err), .fail_valid(fail_valid), .fail_addr(fail_addr),
        .fail_syn(fail_syn), .fail_up(fail_up));

    bist_resp_analyzer #(.DTA_SIZE(DW), .ADR_SIZE(AW), .ERR_CNT_W(EW2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .rd_valid(rd_valid), .rd_up(rd_up),
        .rd_addr(rd_addr), .rd_data(rd_data), .exp_data(exp_data), .test_end(test_end),
        .busy(busy_b), .done(done_b), .status(status_b), .err_cnt(err_cnt_b),
        .count_err(count_err_b), .fail_valid(fail_valid_b), .fail_addr(fail_addr_b),
        .fail_syn(fail_syn_b), .fail_up(fail_up_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          up;
        logic [DW-1:0] rd;
        logic [DW-1:0] ex;
    } rd_t;

    typedef struct {
        int            errs;
        int            errs2;
        bit            cerr;
        bit            st;
        bit            fv;
        logic [AW-1:0] fa;
        logic [DW-1:0] fs;
        bit            fu;
    } exp_t;

    rd_t  reads[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: every rule applied to the whole list of reads at once
    function automatic exp_t model();
        exp_t e;
        int n = 0, errs = 0;
        e.fv = 1'b0; e.fa = '0; e.fs = '0; e.fu = 1'b0;
        foreach (reads[i]) begin
            n++;
            if (reads[i].rd != reads[i].ex) begin
                errs++;
                if (!e.fv) begin
                    e.fv = 1'b1;
                    e.fa = reads[i].addr;
                    e.fs = reads[i].rd ^ reads[i].ex;
                    e.fu = reads[i].up;
                end
            end
        end
        e.errs  = (errs > (1 << EW) - 1)  ? (1 << EW) - 1  : errs;
        e.errs2 = (errs > (1 << EW2) - 1) ? (1 << EW2) - 1 : errs;
        e.cerr  = (n != (1 << (AW + 1)));
        e.st    = (errs == 0) && !e.cerr;
        return e;
    endfunction

    // Monitor: each rising done retires one scoreboard entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("err_cnt",    32'(err_cnt),    32'(e.errs));
                    chk("err_cnt_w2", 32'(err_cnt_b),  32'(e.errs2));
                    chk("count_err",  32'(count_err),  32'(e.cerr));
                    chk("status",     32'(status),     32'(e.st));
                    chk("status_w2",  32'(status_b),   32'(e.st));
                    chk("done_w2",    32'(done_b),     32'd1);
                    chk("fail_valid", 32'(fail_valid), 32'(e.fv));
                    if (e.fv) begin
                        chk("fail_addr", 32'(fail_addr), 32'(e.fa));
                        chk("fail_syn",  32'(fail_syn),  32'(e.fs));
                        chk("fail_up",   32'(fail_up),   32'(e.fu));
                        chk("fail_addr_w2", 32'(fail_addr_b), 32'(e.fa));
                    end
                end
            end
            done_prev = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_clean(input int n);
        rd_t r;
        reads.delete();
        for (int i = 0; i < n; i++) begin
            r.addr = AW'(i);
            r.up   = (i < 16);
            r.ex   = DW'($urandom);
            r.rd   = r.ex;
            reads.push_back(r);
        end
    endtask

    task automatic gen_random(input int n);
        rd_t r;
        reads.delete();
        for (int i = 0; i < n; i++) begin
            r.addr = AW'($urandom);
            r.up   = 1'($urandom);
            r.ex   = DW'($urandom);
            r.rd   = r.ex;
            if ($urandom_range(0, 5) == 0)
                r.rd = r.ex ^ DW'($urandom_range(1, 255));
            reads.push_back(r);
        end
    endtask

    task automatic drive_read(input rd_t r);
        rd_valid = 1'b1;
        rd_addr  = r.addr;
        rd_up    = r.up;
        rd_data  = r.rd;
        exp_data = r.ex;
    endtask

    // Arm, stream the reads back-to-back, end the test, check done timing
    task automatic run(input bit te_last, input bit expect_result);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_armed", 32'(busy), 32'd1);
        chk("armed_err_clear", 32'(err_cnt), 32'd0);
        chk("armed_fail_clear", 32'(fail_valid), 32'd0);
        chk("armed_done_low", 32'(done), 32'd0);
        if (expect_result) sb.push_back(model());
        foreach (reads[i]) begin
            drive_read(reads[i]);
            test_end = te_last && (i == reads.size() - 1);
            tick();
        end
        rd_valid = 1'b0;
        if (!te_last) begin
            test_end = 1'b1;
            tick();
        end
        test_end = 1'b0;
        chk("drain_done_low", 32'(done), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        if (expect_result) begin
            tick();
            chk("done_two_edges", 32'(done), 32'd1);
            chk("result_busy_low", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rd_t r;
        exp_t last;
        rst = 1'b1; start = 1'b0; rd_valid = 1'b0; rd_up = 1'b0; test_end = 1'b0;
        rd_addr = '0; rd_data = '0; exp_data = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_count_err", 32'(count_err), 32'd0);
        chk("rst_fail", 32'({fail_valid, fail_up, fail_addr, fail_syn}), 32'd0);
        rst = 1'b0;

        // Reads and test_end in IDLE are ignored
        r.addr = 4'd1; r.up = 1'b1; r.ex = 8'h00; r.rd = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            drive_read(r);
            test_end = 1'b1;
            tick();
        end
        rd_valid = 1'b0; test_end = 1'b0;
        tick();
        chk("idle_err_cnt", 32'(err_cnt), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // Clean run
        gen_clean(32);
        run(1'b0, 1'b1);

        // Single fault at read #20
        gen_clean(32);
        reads[19].addr = 4'd5; reads[19].up = 1'b1;
        reads[19].ex = 8'hFF; reads[19].rd = 8'hFB;
        run(1'b0, 1'b1);
        last = model();
        tick();
        // Reads while in RESULT change nothing
        for (int i = 0; i < 3; i++) begin
            drive_read(r);
            tick();
        end
        rd_valid = 1'b0;
        tick();
        chk("result_err_hold", 32'(err_cnt), 32'(last.errs));
        chk("result_status_hold", 32'(status), 32'(last.st));
        chk("result_done_hold", 32'(done), 32'd1);
        chk("result_fail_addr_hold", 32'(fail_addr), 32'd5);

        // First-fail hold and saturation
        gen_clean(32);
        reads[3].rd = reads[3].ex ^ 8'h01;
        foreach (reads[i])
            if (i == 7 || i == 9 || i == 11 || i == 12)
                reads[i].rd = reads[i].ex ^ DW'($urandom_range(1, 255));
        run(1'b0, 1'b1);

        // Short test
        gen_clean(31);
        run(1'b0, 1'b1);

        // Last read coincides with test_end
        gen_clean(32);
        run(1'b1, 1'b1);

        // Restart mid-ARMED after two errors
        gen_clean(4);
        reads[0].rd = ~reads[0].ex;
        reads[1].rd = ~reads[1].ex;
        start = 1'b1;
        tick();
        start = 1'b0;
        foreach (reads[i]) begin
            drive_read(reads[i]);
            tick();
        end
        rd_valid = 1'b0;
        tick();
        chk("pre_restart_err", 32'(err_cnt), 32'd2);
        gen_clean(32);
        run(1'b0, 1'b1);

        // Randomized runs
        for (int k = 0; k < 8; k++) begin
            gen_random(k < 4 ? 32 : $urandom_range(29, 34));
            run(1'($urandom), 1'b1);
        end

        // Reset during DRAIN abandons the test
        gen_clean(32);
        reads[2].rd = ~reads[2].ex;
        run(1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_drain_busy", 32'(busy), 32'd0);
        chk("rst_drain_done", 32'(done), 32'd0);
        chk("rst_drain_err", 32'(err_cnt), 32'd0);
        chk("rst_drain_fail", 32'({fail_valid, fail_up, fail_addr, fail_syn}), 32'd0);
        chk("rst_drain_res", 32'({status, count_err}), 32'd0);
        repeat (5) tick();
        chk("rst_drain_no_done", 32'(done), 32'd0);
        chk("rst_drain_idle", 32'(busy), 32'd0);

        repeat (10) begin
            if (sb.size() != 0) tick();
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
